// File: rtl/uart_status_rx.sv
// uart_status_rx: 8N1 receiver for the robot status link; decodes each byte into status fields
// behind a one-entry valid/ready buffer. Build option RX_MAJORITY_EN enables 3-sample voting.
module uart_status_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data_received,
  output logic [2:0] motor_stat,
  output logic [3:0] proximity,
  output logic       format_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 2);

`ifdef RX_MAJORITY_EN
  // The vote completes one cycle after the nominal sample point; restarting the counter at 1
  // keeps every bit period at CLKS_PER_BIT so that extra cycle is paid only once per frame.
  localparam int               START_DEC   = CLKS_PER_BIT / 2;
  localparam int               BIT_DEC     = CLKS_PER_BIT;
  localparam logic [CNT_W-1:0] CNT_RESTART = CNT_W'(1);
`else
  localparam int               START_DEC   = CLKS_PER_BIT / 2 - 1;
  localparam int               BIT_DEC     = CLKS_PER_BIT - 1;
  localparam logic [CNT_W-1:0] CNT_RESTART = '0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             rx_meta_reg;
  logic             rx_s_reg;

  logic             valid_reg;
  logic [7:0]       data_reg;
  logic [2:0]       motor_reg;
  logic [3:0]       prox_reg;
  logic             fmt_reg;
  logic             frame_err_reg;
  logic             overrun_reg;

  logic [CNT_W-1:0] target;
  logic             at_decision;
  logic             bit_val;

  // Two-flop synchroniser; idles high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_comb begin
    target      = (state_reg == ST_START) ? CNT_W'(START_DEC) : CNT_W'(BIT_DEC);
    at_decision = (cnt_reg == target);
  end

`ifdef RX_MAJORITY_EN
  logic vote_a_reg;
  logic vote_b_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vote_a_reg <= 1'b1;
      vote_b_reg <= 1'b1;
    end else begin
      if (cnt_reg == target - CNT_W'(2)) vote_a_reg <= rx_s_reg;
      if (cnt_reg == target - CNT_W'(1)) vote_b_reg <= rx_s_reg;
    end
  end

  assign bit_val = (vote_a_reg & vote_b_reg) | (vote_a_reg & rx_s_reg) | (vote_b_reg & rx_s_reg);
`else
  assign bit_val = rx_s_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      valid_reg     <= 1'b0;
      data_reg      <= '0;
      motor_reg     <= '0;
      prox_reg      <= '0;
      fmt_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      if (valid_reg && ready) valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (!rx_s_reg) begin
            state_reg <= ST_START;
            cnt_reg   <= '0;
          end
        end

        ST_START: begin
          if (at_decision) begin
            if (bit_val) begin
              state_reg <= ST_IDLE;
            end else begin
              state_reg   <= ST_DATA;
              cnt_reg     <= CNT_RESTART;
              bit_idx_reg <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (at_decision) begin
            shift_reg <= {bit_val, shift_reg[7:1]};
            cnt_reg   <= CNT_RESTART;
            if (bit_idx_reg == 3'd7) state_reg <= ST_STOP;
            else bit_idx_reg <= bit_idx_reg + 3'd1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (at_decision) begin
            cnt_reg <= '0;
            if (bit_val) begin
              // A load wins over a same-cycle consume; only an unconsumed frame counts as overrun.
              state_reg   <= ST_IDLE;
              valid_reg   <= 1'b1;
              data_reg    <= shift_reg;
              motor_reg   <= shift_reg[7:5];
              prox_reg    <= shift_reg[4:1];
              fmt_reg     <= shift_reg[0] | (shift_reg[7:5] == 3'b110);
              overrun_reg <= valid_reg & ~ready;
            end else begin
              state_reg     <= ST_BREAK;
              frame_err_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        ST_BREAK: begin
          if (rx_s_reg) state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign valid         = valid_reg;
  assign data_received = data_reg;
  assign motor_stat    = motor_reg;
  assign proximity     = prox_reg;
  assign format_err    = fmt_reg;
  assign frame_err     = frame_err_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_uart_status_rx.sv
// tb_uart_status_rx: table-driven, hand-sequenced and randomized checks of uart_status_rx
// at CLKS_PER_BIT=16, with a cycle-level handshake reference model for the random phase.
`timescale 1ns/1ps
module tb_uart_status_rx;
  localparam int CPB      = 16;
  localparam int LOAD_LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       valid;
  logic [7:0] data_received;
  logic [2:0] motor_stat;
  logic [3:0] proximity;
  logic       format_err;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       exp_valid;
    logic [2:0] exp_motor;
    logic [3:0] exp_prox;
    logic       exp_fmt;
    int         exp_fe;
  } vec_t;

  typedef struct {
    int         at;
    logic [7:0] b;
    logic       good;
  } ev_t;

  vec_t       vecs[8];
  ev_t        evq[$];
  ev_t        ev;
  logic       rand_done = 1'b0;
  logic       mv;
  logic [7:0] md;
  logic       rdy;
  logic       exp_ov;
  logic       exp_fe;
  logic [7:0] rb;
  logic       rgood;
  int         rgap;

  uart_status_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .ready        (ready),
    .valid        (valid),
    .data_received(data_received),
    .motor_stat   (motor_stat),
    .proximity    (proximity),
    .format_err   (format_err),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // All drive tasks enter and leave 2 ns after a rising edge.
  task automatic tx_level(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int hold_low);
    start_cyc = cyc + 1;
    tx_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) tx_level(b[i], CPB);
    tx_level(stop_bit, CPB);
    if (hold_low > 0) tx_level(1'b0, hold_low);
    rx = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        at = cyc - start_cyc;
        break;
      end
    end
  endtask

  task automatic consume();
    ready = 1'b1;
    @(posedge clk);
    #2;
    ready = 1'b0;
    chk("consume_valid", valid, 0);
  endtask

  task automatic chk_fields(input string tag, input logic [7:0] b, input logic [2:0] m,
                            input logic [3:0] p, input logic f);
    chk({tag, "_data"}, data_received, b);
    chk({tag, "_motor"}, motor_stat, m);
    chk({tag, "_prox"}, proximity, p);
    chk({tag, "_fmt"}, format_err, f);
  endtask

  initial begin
    int at;
    int fe0;
    int ov0;

    vecs[0] = '{8'h26, 1'b1, 1'b1, 3'd1, 4'h3, 1'b0, 0};
    vecs[1] = '{8'hC1, 1'b1, 1'b1, 3'd6, 4'h0, 1'b1, 0};
    vecs[2] = '{8'h42, 1'b1, 1'b1, 3'd2, 4'h1, 1'b0, 0};
    vecs[3] = '{8'hA4, 1'b1, 1'b1, 3'd5, 4'h2, 1'b0, 0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 3'd0, 4'h0, 1'b1, 0};
    vecs[5] = '{8'hFE, 1'b1, 1'b1, 3'd7, 4'hF, 1'b0, 0};
    vecs[6] = '{8'hDD, 1'b1, 1'b1, 3'd6, 4'hE, 1'b1, 0};
    vecs[7] = '{8'h55, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", valid, 0);
    chk_fields("rst", 8'h00, 3'd0, 4'h0, 1'b0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    idle(5);

    // Exact load latency with ready held high: valid lasts one cycle
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    ready = 1'b1;
    fork
      send_frame(8'h26, 1'b1, 0);
      begin
        wait_valid(400, at);
        chk("lat_0x26", at, LOAD_LAT);
        chk_fields("lat", 8'h26, 3'd1, 4'h3, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_valid_1cycle", valid, 0);
      end
    join
    ready = 1'b0;
    idle(5);
    chk("lat_no_fe", fe_cnt - fe0, 0);
    chk("lat_no_ov", ov_cnt - ov0, 0);

    // Table of single frames received with ready low
    for (int i = 0; i < 8; i++) begin
      fe0 = fe_cnt;
      send_frame(vecs[i].b, vecs[i].stop, 0);
      idle(10);
      chk($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
      if (vecs[i].exp_valid) begin
        chk_fields($sformatf("vec%0d", i), vecs[i].b, vecs[i].exp_motor, vecs[i].exp_prox,
                   vecs[i].exp_fmt);
        idle(40);
        chk($sformatf("vec%0d_hold", i), valid, 1);
        consume();
      end
    end

    // Back-to-back frames with ready low: one overrun, newest data kept
    ov0 = ov_cnt;
    send_frame(8'h42, 1'b1, 0);
    send_frame(8'hA4, 1'b1, 0);
    idle(10);
    chk("ovr_count", ov_cnt - ov0, 1);
    chk("ovr_valid", valid, 1);
    chk_fields("ovr", 8'hA4, 3'd5, 4'h2, 1'b0);
    consume();

    // Load coinciding with a consume: no overrun, valid stays high
    send_frame(8'h3C, 1'b1, 0);
    idle(5);
    chk("simul_pre_valid", valid, 1);
    ov0 = ov_cnt;
    fork
      send_frame(8'h5A, 1'b1, 0);
      begin
        int t;
        #1;
        t = start_cyc + LOAD_LAT - 1;
        while (cyc < t) begin
          @(posedge clk);
          #1;
        end
        #1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk("simul_valid", valid, 1);
        chk("simul_data", data_received, 8'h5A);
        #1;
        ready = 1'b0;
      end
    join
    idle(5);
    chk("simul_no_ov", ov_cnt - ov0, 0);
    chk("simul_hold", valid, 1);
    consume();

    // Bad stop bit then a long break: one frame error, then normal reception
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 100);
    idle(10);
    chk("brk_fe", fe_cnt - fe0, 1);
    chk("brk_valid", valid, 0);
    send_frame(8'h10, 1'b1, 0);
    idle(10);
    chk("brk_next_valid", valid, 1);
    chk_fields("brk_next", 8'h10, 3'd0, 4'h8, 1'b0);
    chk("brk_fe_once", fe_cnt - fe0, 1);
    consume();

    // Short glitch is a false start
    fe0 = fe_cnt;
    tx_level(1'b0, 4);
    rx = 1'b1;
    idle(200);
    chk("glitch_valid", valid, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);

    // Reset in the middle of a frame clears the buffer and the partial frame
    send_frame(8'h33, 1'b1, 0);
    idle(10);
    chk("pre_rst_valid", valid, 1);
    tx_level(1'b0, CPB);
    for (int i = 0; i < 3; i++) tx_level(((8'h7E >> i) & 8'h01) != 0, CPB);
    tx_level(1'b1, CPB / 2);
    rst = 1'b1;
    idle(2);
    chk("midrst_valid", valid, 0);
    chk_fields("midrst", 8'h00, 3'd0, 4'h0, 1'b0);
    rst = 1'b0;
    idle(60);
    chk("post_rst_valid", valid, 0);
    send_frame(8'h08, 1'b1, 0);
    idle(10);
    chk("post_rst_frame_valid", valid, 1);
    chk_fields("post_rst", 8'h08, 3'd0, 4'h4, 1'b0);
    consume();
    idle(5);

    // Randomized frames, gaps and ready against a cycle-level handshake model
    mv = 1'b0;
    md = 8'h00;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          rb    = 8'($urandom);
          rgood = ($urandom_range(0, 5) != 0);
          rgap  = rgood ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
          ev.at   = cyc + 1 + LOAD_LAT;
          ev.b    = rb;
          ev.good = rgood;
          evq.push_back(ev);
          send_frame(rb, rgood, 0);
          idle(rgap);
        end
        idle(20);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #2;
          ready = ($urandom_range(0, 1) != 0);
        end
        ready = 1'b0;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          rdy    = ready;
          exp_ov = 1'b0;
          exp_fe = 1'b0;
          if (mv && rdy) mv = 1'b0;
          if (evq.size() > 0 && evq[0].at == cyc) begin
            ev = evq.pop_front();
            if (ev.good) begin
              exp_ov = mv;
              mv     = 1'b1;
              md     = ev.b;
            end else begin
              exp_fe = 1'b1;
            end
          end
          chk("rand_valid", valid, mv);
          chk("rand_overrun", overrun, exp_ov);
          chk("rand_frame_err", frame_err, exp_fe);
          if (mv) begin
            chk("rand_data", data_received, md);
            chk("rand_motor", motor_stat, md / 32);
            chk("rand_prox", proximity, (md / 2) % 16);
            chk("rand_fmt", format_err, ((md % 2) == 1 || (md / 32) == 6) ? 1 : 0);
          end
        end
      end
    join
    chk("rand_all_events_seen", evq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
